// File: rtl/axi4l_ipif_pkg.sv
// axi4l_ipif_pkg: shared definitions for the AXI4-Lite to up_ipif crossbar.
// Holds the AXI response codes, the per-direction transfer state encoding
// and a constant-evaluable ceil(log2()) helper used for width derivation.
package axi4l_ipif_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } xfer_state_e;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4l_ipif_xbar_if.sv
// axi4l_ipif_xbar_if: AXI4-Lite bus bundle (32-bit address, DW-bit data).
// Ports: aw*/w*/b* write channels, ar*/r* read channels.
// Modports: master drives addresses/data/ready-for-response, slave the rest.
interface axi4l_ipif_xbar_if #(
    parameter int DW = 32
);
    logic [31:0]     awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [31:0]     araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4l_ipif_xfer.sv
// axi4l_ipif_xfer: one request/ack/timeout sequencer (used once per direction).
// Ports: clk/rst; start (accepted, mapped channel), start_err (accepted,
// unmapped), ch (decoded channel), ack (per-channel acks), resp_ready (AXI
// b/r ready); req (one-hot 1-cycle pulse), resp_valid/resp (AXI response),
// idle (ready for a new handshake), ack_hit (matching ack this cycle),
// ch_sel (channel of the transfer in flight).
module axi4l_ipif_xfer
    import axi4l_ipif_pkg::*;
#(
    parameter int  C_NUM_CH  = 4,
    parameter int  C_TIMEOUT = 255,
    localparam int CH_W      = (clog2(C_NUM_CH) > 0) ? clog2(C_NUM_CH) : 1,
    localparam int TO_W      = clog2(C_TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                start_err,
    input  logic [CH_W-1:0]     ch,
    input  logic [C_NUM_CH-1:0] ack,
    input  logic                resp_ready,
    output logic [C_NUM_CH-1:0] req,
    output logic                resp_valid,
    output logic [1:0]          resp,
    output logic                idle,
    output logic                ack_hit,
    output logic [CH_W-1:0]     ch_sel
);

    localparam logic [C_NUM_CH-1:0] REQ_ONE = C_NUM_CH'(1'b1);
    localparam logic [TO_W-1:0]     TO_MAX  = TO_W'(C_TIMEOUT);
    localparam logic [TO_W-1:0]     TO_LAST = TO_W'(C_TIMEOUT - 1);

    xfer_state_e     state_r;
    logic [TO_W-1:0] cnt_r;
    logic [TO_W-1:0] cnt_inc_s;

    assign idle = (state_r == IDLE);

    // Only the selected channel's ack counts, and only while waiting (REQ included).
    always_comb begin
        ack_hit = 1'b0;
        if ((state_r == REQ) || (state_r == WAIT)) begin
            ack_hit = ack[ch_sel];
        end else begin
            ack_hit = 1'b0;
        end
    end

    // Saturating increment of the timeout counter.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (cnt_r == TO_MAX) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    // Transfer sequencer with registered req/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            req        <= '0;
            resp_valid <= 1'b0;
            resp       <= RESP_OKAY;
            cnt_r      <= '0;
            ch_sel     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= REQ;
                        req     <= REQ_ONE << ch;
                        ch_sel  <= ch;
                        cnt_r   <= '0;
                    end else if (start_err) begin
                        // Unmapped channel: answer directly, no req pulse.
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp       <= RESP_DECERR;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ, WAIT: begin
                    req   <= '0;
                    cnt_r <= cnt_inc_s;
                    if (ack_hit) begin
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp       <= RESP_OKAY;
                    end else if (cnt_r >= TO_LAST) begin
                        // This cycle was the C_TIMEOUT-th one without an ack.
                        state_r    <= RESP;
                        resp_valid <= 1'b1;
                        resp       <= RESP_SLVERR;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_r    <= IDLE;
                        resp_valid <= 1'b0;
                        resp       <= RESP_OKAY;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    req        <= '0;
                    resp_valid <= 1'b0;
                    resp       <= RESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/axi4l_ipif_xbar.sv
// axi4l_ipif_xbar: AXI4-Lite slave fanning out to C_NUM_CH up_ipif ports.
// Ports: aclk, areset (sync, active high); s_axi (AXI4-Lite slave);
// up_wr_addr/req/be/din + up_wr_ack (write port per channel);
// up_rd_addr/req + up_rd_dout/up_rd_ack (read port per channel).
// The channel is taken from the address field just above the window bits;
// write and read directions each own an independent sequencer.
module axi4l_ipif_xbar
    import axi4l_ipif_pkg::*;
#(
    parameter int  C_NUM_CH     = 4,
    parameter int  C_CH_ADDR_W  = 12,
    parameter int  C_DATA_WIDTH = 32,
    parameter int  C_TIMEOUT    = 255,
    localparam int BE_W         = C_DATA_WIDTH / 8,
    localparam int L2           = clog2(BE_W),
    localparam int UA_W         = C_CH_ADDR_W - L2,
    localparam int CH_W         = (clog2(C_NUM_CH) > 0) ? clog2(C_NUM_CH) : 1
) (
    input  logic                           aclk,
    input  logic                           areset,
    axi4l_ipif_xbar_if.slave               s_axi,
    output logic [UA_W-1:0]                up_wr_addr,
    output logic [C_NUM_CH-1:0]            up_wr_req,
    output logic [BE_W-1:0]                up_wr_be,
    output logic [C_DATA_WIDTH-1:0]        up_wr_din,
    input  logic [C_NUM_CH-1:0]            up_wr_ack,
    output logic [UA_W-1:0]                up_rd_addr,
    output logic [C_NUM_CH-1:0]            up_rd_req,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] up_rd_dout,
    input  logic [C_NUM_CH-1:0]            up_rd_ack
);

    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(C_NUM_CH);

    logic [CH_W-1:0] aw_ch_s, ar_ch_s;
    logic            aw_bad_s, ar_bad_s, aw_hs_s, ar_hs_s;
    logic            aw_rdy_r, ar_rdy_r;
    logic            wr_idle_s, rd_idle_s, wr_ack_hit_s, rd_ack_hit_s;
    logic            wr_resp_valid_s, rd_resp_valid_s;
    logic [1:0]      wr_resp_s, rd_resp_s;
    logic [CH_W-1:0] wr_ch_sel_s, rd_ch_sel_s;
    logic [C_DATA_WIDTH-1:0] rdata_r;
    logic            unused_s;

    // Channel decode; a single-channel build has no channel field at all.
    always_comb begin
        aw_ch_s = '0;
        ar_ch_s = '0;
        if (C_NUM_CH == 1) begin
            aw_ch_s = '0;
            ar_ch_s = '0;
        end else begin
            aw_ch_s = s_axi.awaddr[C_CH_ADDR_W +: CH_W];
            ar_ch_s = s_axi.araddr[C_CH_ADDR_W +: CH_W];
        end
    end

    // Handshake qualification and unmapped-channel detection.
    always_comb begin
        aw_bad_s = ({1'b0, aw_ch_s} >= NUM_CH_V);
        ar_bad_s = ({1'b0, ar_ch_s} >= NUM_CH_V);
        aw_hs_s  = aw_rdy_r & s_axi.awvalid & s_axi.wvalid;
        ar_hs_s  = ar_rdy_r & s_axi.arvalid;
    end

    axi4l_ipif_xfer #(.C_NUM_CH(C_NUM_CH), .C_TIMEOUT(C_TIMEOUT)) u_wr_xfer (
        .clk(aclk), .rst(areset),
        .start(aw_hs_s & ~aw_bad_s), .start_err(aw_hs_s & aw_bad_s), .ch(aw_ch_s),
        .ack(up_wr_ack), .resp_ready(s_axi.bready),
        .req(up_wr_req), .resp_valid(wr_resp_valid_s), .resp(wr_resp_s),
        .idle(wr_idle_s), .ack_hit(wr_ack_hit_s), .ch_sel(wr_ch_sel_s)
    );

    axi4l_ipif_xfer #(.C_NUM_CH(C_NUM_CH), .C_TIMEOUT(C_TIMEOUT)) u_rd_xfer (
        .clk(aclk), .rst(areset),
        .start(ar_hs_s & ~ar_bad_s), .start_err(ar_hs_s & ar_bad_s), .ch(ar_ch_s),
        .ack(up_rd_ack), .resp_ready(s_axi.rready),
        .req(up_rd_req), .resp_valid(rd_resp_valid_s), .resp(rd_resp_s),
        .idle(rd_idle_s), .ack_hit(rd_ack_hit_s), .ch_sel(rd_ch_sel_s)
    );

    assign s_axi.awready = aw_rdy_r;
    assign s_axi.wready  = aw_rdy_r;
    assign s_axi.bvalid  = wr_resp_valid_s;
    assign s_axi.bresp   = wr_resp_s;
    assign s_axi.arready = ar_rdy_r;
    assign s_axi.rvalid  = rd_resp_valid_s;
    assign s_axi.rresp   = rd_resp_s;
    assign s_axi.rdata   = rdata_r;

    // AW and W are accepted together as a single one-cycle pulse.
    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_rdy_r <= 1'b0;
        end else if (aw_rdy_r) begin
            aw_rdy_r <= 1'b0;
        end else if (wr_idle_s && s_axi.awvalid && s_axi.wvalid) begin
            aw_rdy_r <= 1'b1;
        end else begin
            aw_rdy_r <= 1'b0;
        end
    end

    // AR accept pulse, only while the read path is idle.
    always_ff @(posedge aclk) begin
        if (areset) begin
            ar_rdy_r <= 1'b0;
        end else if (ar_rdy_r) begin
            ar_rdy_r <= 1'b0;
        end else if (rd_idle_s && s_axi.arvalid) begin
            ar_rdy_r <= 1'b1;
        end else begin
            ar_rdy_r <= 1'b0;
        end
    end

    // Write address/data/strobes, captured once per accepted transaction.
    always_ff @(posedge aclk) begin
        if (areset) begin
            up_wr_addr <= '0;
            up_wr_be   <= '0;
            up_wr_din  <= '0;
        end else if (aw_hs_s) begin
            up_wr_addr <= s_axi.awaddr[C_CH_ADDR_W-1:L2];
            up_wr_be   <= s_axi.wstrb;
            up_wr_din  <= s_axi.wdata;
        end else begin
            up_wr_addr <= up_wr_addr;
        end
    end

    // Read address and data; rdata stays zero unless the selected ack arrives.
    always_ff @(posedge aclk) begin
        if (areset) begin
            up_rd_addr <= '0;
            rdata_r    <= '0;
        end else if (ar_hs_s) begin
            up_rd_addr <= s_axi.araddr[C_CH_ADDR_W-1:L2];
            rdata_r    <= '0;
        end else if (rd_ack_hit_s) begin
            rdata_r <= up_rd_dout[rd_ch_sel_s*C_DATA_WIDTH +: C_DATA_WIDTH];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign unused_s = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr, s_axi.araddr,
                        wr_ack_hit_s, wr_ch_sel_s};

endmodule

// File: tb/tb_axi4l_ipif_xbar.sv
module tb_axi4l_ipif_xbar;
    import axi4l_ipif_pkg::*;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t wr_q[$];
    exp_t rd_q[$];

    always #5 aclk = ~aclk;

    // Main instance: 4 channels, short timeout
    axi4l_ipif_xbar_if #(.DW(32)) ax ();
    logic [9:0]   up_wr_addr, up_rd_addr;
    logic [3:0]   up_wr_req, up_wr_be, up_wr_ack, up_rd_req, up_rd_ack;
    logic [31:0]  up_wr_din;
    logic [127:0] up_rd_dout;

    axi4l_ipif_xbar #(.C_NUM_CH(4), .C_CH_ADDR_W(12), .C_DATA_WIDTH(32), .C_TIMEOUT(8)) dut (
        .aclk(aclk), .areset(areset), .s_axi(ax.slave),
        .up_wr_addr(up_wr_addr), .up_wr_req(up_wr_req), .up_wr_be(up_wr_be),
        .up_wr_din(up_wr_din), .up_wr_ack(up_wr_ack),
        .up_rd_addr(up_rd_addr), .up_rd_req(up_rd_req),
        .up_rd_dout(up_rd_dout), .up_rd_ack(up_rd_ack)
    );

    // Second instance: 3 channels, so channel 3 is unmapped
    axi4l_ipif_xbar_if #(.DW(32)) a3 ();
    logic [9:0]  u3_wr_addr, u3_rd_addr;
    logic [2:0]  u3_wr_req, u3_wr_ack, u3_rd_req, u3_rd_ack;
    logic [3:0]  u3_wr_be;
    logic [31:0] u3_wr_din;
    logic [95:0] u3_rd_dout;

    axi4l_ipif_xbar #(.C_NUM_CH(3), .C_CH_ADDR_W(12), .C_DATA_WIDTH(32), .C_TIMEOUT(8)) dut3 (
        .aclk(aclk), .areset(areset), .s_axi(a3.slave),
        .up_wr_addr(u3_wr_addr), .up_wr_req(u3_wr_req), .up_wr_be(u3_wr_be),
        .up_wr_din(u3_wr_din), .up_wr_ack(u3_wr_ack),
        .up_rd_addr(u3_rd_addr), .up_rd_req(u3_rd_req),
        .up_rd_dout(u3_rd_dout), .up_rd_ack(u3_rd_ack)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_awready"}, 64'(ax.awready), 64'd0);
        chk({tag, "_wready"},  64'(ax.wready),  64'd0);
        chk({tag, "_bvalid"},  64'(ax.bvalid),  64'd0);
        chk({tag, "_bresp"},   64'(ax.bresp),   64'(RESP_OKAY));
        chk({tag, "_arready"}, 64'(ax.arready), 64'd0);
        chk({tag, "_rvalid"},  64'(ax.rvalid),  64'd0);
        chk({tag, "_rresp"},   64'(ax.rresp),   64'(RESP_OKAY));
        chk({tag, "_rdata"},   64'(ax.rdata),   64'd0);
        chk({tag, "_wr_req"},  64'(up_wr_req),  64'd0);
        chk({tag, "_rd_req"},  64'(up_rd_req),  64'd0);
        chk({tag, "_wr_addr"}, 64'(up_wr_addr), 64'd0);
        chk({tag, "_wr_be"},   64'(up_wr_be),   64'd0);
        chk({tag, "_wr_din"},  64'(up_wr_din),  64'd0);
        chk({tag, "_rd_addr"}, 64'(up_rd_addr), 64'd0);
    endtask

    // Present AW+W; return just after the handshake edge.
    task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        ax.awaddr = a; ax.awvalid = 1'b1;
        ax.wdata = d; ax.wstrb = s; ax.wvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (ax.awready === 1'b1 && ax.wready === 1'b1) ok = 1'b1;
        end
        if (ok) step();
        ax.awvalid = 1'b0; ax.wvalid = 1'b0;
        chk("aw_accept", 64'(ok), 64'd1);
    endtask

    task automatic rd_issue(input logic [31:0] a);
        bit ok;
        ok = 1'b0;
        ax.araddr = a; ax.arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (ax.arready === 1'b1) ok = 1'b1;
        end
        if (ok) step();
        ax.arvalid = 1'b0;
        chk("ar_accept", 64'(ok), 64'd1);
    endtask

    task automatic collect_b(input string tag);
        bit   got;
        exp_t e;
        got = 1'b0;
        ax.bready = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            if (ax.bvalid === 1'b1) got = 1'b1;
            else step();
        end
        chk({tag, "_bvalid_seen"}, 64'(got), 64'd1);
        chk({tag, "_wr_q_nonempty"}, 64'(wr_q.size() > 0), 64'd1);
        if (got && wr_q.size() > 0) begin
            e = wr_q.pop_front();
            chk({tag, "_bresp"}, 64'(ax.bresp), 64'(e.resp));
        end
        step();
        ax.bready = 1'b0;
        chk({tag, "_bvalid_drop"}, 64'(ax.bvalid), 64'd0);
    endtask

    task automatic collect_r(input string tag);
        bit   got;
        exp_t e;
        got = 1'b0;
        ax.rready = 1'b1;
        for (int i = 0; i < 30 && !got; i++) begin
            if (ax.rvalid === 1'b1) got = 1'b1;
            else step();
        end
        chk({tag, "_rvalid_seen"}, 64'(got), 64'd1);
        chk({tag, "_rd_q_nonempty"}, 64'(rd_q.size() > 0), 64'd1);
        if (got && rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk({tag, "_rresp"}, 64'(ax.rresp), 64'(e.resp));
            chk({tag, "_rdata"}, 64'(ax.rdata), 64'(e.data));
        end
        step();
        ax.rready = 1'b0;
        chk({tag, "_rvalid_drop"}, 64'(ax.rvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        exp_t e;
        ax.awaddr = 32'd0; ax.awprot = 3'd0; ax.awvalid = 1'b0;
        ax.wdata = 32'd0; ax.wstrb = 4'd0; ax.wvalid = 1'b0; ax.bready = 1'b0;
        ax.araddr = 32'd0; ax.arprot = 3'd0; ax.arvalid = 1'b0; ax.rready = 1'b0;
        a3.awaddr = 32'd0; a3.awprot = 3'd0; a3.awvalid = 1'b0;
        a3.wdata = 32'd0; a3.wstrb = 4'd0; a3.wvalid = 1'b0; a3.bready = 1'b0;
        a3.araddr = 32'd0; a3.arprot = 3'd0; a3.arvalid = 1'b0; a3.rready = 1'b0;
        up_wr_ack = 4'd0; up_rd_ack = 4'd0;
        up_rd_dout = {32'h1234_5678, 32'hD2D2_2222, 32'hD1D1_1111, 32'hD0D0_0000};
        u3_wr_ack = 3'd0; u3_rd_ack = 3'd0;
        u3_rd_dout = {32'h3333_3333, 32'h2222_2222, 32'h5555_AAAA};

        // Reset state
        areset = 1'b1;
        step(); step();
        chk_reset("rst");
        areset = 1'b0;
        step();

        // Write ch1 word 1, ack three cycles after the req pulse
        wr_issue(32'h0000_1004, 32'hA5A5_5A5A, 4'hF);
        wr_q.push_back('{resp: RESP_OKAY, data: 32'd0});
        chk("w1_req", 64'(up_wr_req), 64'h2);
        chk("w1_addr", 64'(up_wr_addr), 64'd1);
        chk("w1_din", 64'(up_wr_din), 64'hA5A5_5A5A);
        chk("w1_be", 64'(up_wr_be), 64'hF);
        step();
        chk("w1_req_pulse", 64'(up_wr_req), 64'd0);
        chk("w1_bvalid_early", 64'(ax.bvalid), 64'd0);
        step();
        chk("w1_bvalid_wait", 64'(ax.bvalid), 64'd0);
        up_wr_ack = 4'b0010;
        step();
        up_wr_ack = 4'b0000;
        chk("w1_bvalid_after_ack", 64'(ax.bvalid), 64'd1);
        chk("w1_din_held", 64'(up_wr_din), 64'hA5A5_5A5A);
        collect_b("w1");

        // Read ch3 word 2, ack in the req cycle
        rd_issue(32'h0000_3008);
        rd_q.push_back('{resp: RESP_OKAY, data: 32'h1234_5678});
        chk("r1_req", 64'(up_rd_req), 64'h8);
        chk("r1_addr", 64'(up_rd_addr), 64'd2);
        chk("r1_rvalid_early", 64'(ax.rvalid), 64'd0);
        up_rd_ack = 4'b1000;
        step();
        up_rd_ack = 4'b0000;
        chk("r1_rvalid_latency", 64'(ax.rvalid), 64'd1);
        collect_r("r1");

        // Timeout: no matching ack; wrong-channel ack in WAIT, late ack in RESP
        wr_issue(32'h0000_2000, 32'h1111_2222, 4'hF);
        wr_q.push_back('{resp: RESP_SLVERR, data: 32'd0});
        chk("to_req", 64'(up_wr_req), 64'h4);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            up_wr_ack = (k == 2) ? 4'b0010 : ((k == 10) ? 4'b0100 : 4'b0000);
            if (ax.bvalid === 1'b1 && lat == 0) lat = k;
        end
        up_wr_ack = 4'b0000;
        chk("to_latency", 64'(lat), 64'd8);
        chk("to_bvalid_held", 64'(ax.bvalid), 64'd1);
        chk("to_bresp_held", 64'(ax.bresp), 64'(RESP_SLVERR));
        collect_b("to");
        wr_issue(32'h0000_2000, 32'h3333_4444, 4'h1);
        wr_q.push_back('{resp: RESP_OKAY, data: 32'd0});
        up_wr_ack = 4'b0100;
        step();
        up_wr_ack = 4'b0000;
        chk("to_next_bvalid", 64'(ax.bvalid), 64'd1);
        collect_b("to_next");

        // AW without W plus a concurrent read of ch0, both responses back-pressured
        ax.awaddr = 32'h0000_000C; ax.awvalid = 1'b1; ax.wvalid = 1'b0;
        ax.wdata = 32'h0BAD_F00D; ax.wstrb = 4'h3;
        ax.araddr = 32'h0000_0010; ax.arvalid = 1'b1;
        step();
        chk("c_awready_1", 64'(ax.awready), 64'd0);
        chk("c_arready", 64'(ax.arready), 64'd1);
        step();
        ax.arvalid = 1'b0;
        chk("c_awready_2", 64'(ax.awready), 64'd0);
        chk("c_rd_req", 64'(up_rd_req), 64'h1);
        chk("c_rd_addr", 64'(up_rd_addr), 64'd4);
        rd_q.push_back('{resp: RESP_OKAY, data: 32'hD0D0_0000});
        up_rd_ack = 4'b0001;
        step();
        up_rd_ack = 4'b0000;
        up_rd_dout[31:0] = 32'hEEEE_EEEE;
        chk("c_awready_3", 64'(ax.awready), 64'd0);
        chk("c_rvalid_1", 64'(ax.rvalid), 64'd1);
        step();
        chk("c_awready_4", 64'(ax.awready), 64'd0);
        chk("c_rvalid_2", 64'(ax.rvalid), 64'd1);
        chk("c_rdata_2", 64'(ax.rdata), 64'hD0D0_0000);
        step();
        chk("c_awready_5", 64'(ax.awready), 64'd0);
        chk("c_wready_5", 64'(ax.wready), 64'd0);
        chk("c_rdata_3", 64'(ax.rdata), 64'hD0D0_0000);
        ax.wvalid = 1'b1;
        step();
        chk("c_awready_w", 64'(ax.awready), 64'd1);
        chk("c_rvalid_4", 64'(ax.rvalid), 64'd1);
        ax.rready = 1'b1;
        chk("c_rd_q_nonempty", 64'(rd_q.size() > 0), 64'd1);
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk("c_rresp", 64'(ax.rresp), 64'(e.resp));
            chk("c_rdata", 64'(ax.rdata), 64'(e.data));
        end
        step();
        ax.awvalid = 1'b0; ax.wvalid = 1'b0; ax.rready = 1'b0;
        chk("c_rvalid_drop", 64'(ax.rvalid), 64'd0);
        chk("c_wr_req", 64'(up_wr_req), 64'h1);
        chk("c_wr_addr", 64'(up_wr_addr), 64'd3);
        chk("c_wr_din", 64'(up_wr_din), 64'h0BAD_F00D);
        chk("c_wr_be", 64'(up_wr_be), 64'h3);
        wr_q.push_back('{resp: RESP_OKAY, data: 32'd0});
        up_wr_ack = 4'b0001;
        step();
        up_wr_ack = 4'b0000;
        chk("c_bvalid", 64'(ax.bvalid), 64'd1);
        collect_b("c");

        // Reset in WAIT aborts silently; the next write (upper bits ignored) completes
        wr_issue(32'h8000_5010, 32'hCAFE_0001, 4'h5);
        chk("rw_req", 64'(up_wr_req), 64'h2);
        step(); step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        chk_reset("rw");
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rw_no_resp", 64'(ax.bvalid), 64'd0);
        end
        wr_issue(32'h8000_5010, 32'h0000_BEEF, 4'hC);
        chk("rw2_req", 64'(up_wr_req), 64'h2);
        chk("rw2_addr", 64'(up_wr_addr), 64'd4);
        chk("rw2_din", 64'(up_wr_din), 64'h0000_BEEF);
        chk("rw2_be", 64'(up_wr_be), 64'hC);
        wr_q.push_back('{resp: RESP_OKAY, data: 32'd0});
        up_wr_ack = 4'b0010;
        step();
        up_wr_ack = 4'b0000;
        chk("rw2_bvalid", 64'(ax.bvalid), 64'd1);
        collect_b("rw2");

        // 3-channel instance: good read, then DECERR read and write on ch3
        a3.araddr = 32'h0000_0000; a3.arvalid = 1'b1;
        step();
        chk("d_arready", 64'(a3.arready), 64'd1);
        step();
        a3.arvalid = 1'b0;
        chk("d_rd_req", 64'(u3_rd_req), 64'h1);
        u3_rd_ack = 3'b001;
        step();
        u3_rd_ack = 3'b000;
        chk("d_ok_rvalid", 64'(a3.rvalid), 64'd1);
        chk("d_ok_rdata", 64'(a3.rdata), 64'h5555_AAAA);
        a3.rready = 1'b1;
        step();
        a3.rready = 1'b0;
        a3.araddr = 32'h0000_3000; a3.arvalid = 1'b1;
        step();
        chk("d_arready2", 64'(a3.arready), 64'd1);
        step();
        a3.arvalid = 1'b0;
        chk("d_no_rd_req", 64'(u3_rd_req), 64'd0);
        chk("d_rvalid", 64'(a3.rvalid), 64'd1);
        chk("d_rresp", 64'(a3.rresp), 64'(RESP_DECERR));
        chk("d_rdata", 64'(a3.rdata), 64'd0);
        a3.rready = 1'b1;
        step();
        a3.rready = 1'b0;
        chk("d_rvalid_drop", 64'(a3.rvalid), 64'd0);
        chk("d_no_rd_req2", 64'(u3_rd_req), 64'd0);
        a3.awaddr = 32'h0000_7000; a3.awvalid = 1'b1;
        a3.wdata = 32'h0000_0001; a3.wstrb = 4'hF; a3.wvalid = 1'b1;
        step();
        chk("dw_awready", 64'(a3.awready), 64'd1);
        step();
        a3.awvalid = 1'b0; a3.wvalid = 1'b0;
        chk("dw_no_wr_req", 64'(u3_wr_req), 64'd0);
        chk("dw_bvalid", 64'(a3.bvalid), 64'd1);
        chk("dw_bresp", 64'(a3.bresp), 64'(RESP_DECERR));
        a3.bready = 1'b1;
        step();
        a3.bready = 1'b0;
        chk("dw_bvalid_drop", 64'(a3.bvalid), 64'd0);

        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
